adc128s022_reader: RTL



---
 rtl/adc128s022_reader.sv | 103 ++++++++++
 1 files changed

// File: rtl/adc128s022_reader.sv
// adc128s022_reader: SPI initiator running one 16-SCLK ADC128S022 frame per start, returning a 12-bit result tagged with its channel.
module adc128s022_reader #(
  parameter int CLK_DIV = 8
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  channel,
  output logic        busy,
  output logic        valid,
  output logic [11:0] data,
  output logic [2:0]  data_channel,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_saddr,
  input  logic        adc_sdat
);
  localparam int PW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;
  state_t state, state_n;
  logic [PW-1:0] ph, ph_n;
  logic [3:0] bc, bc_n;
  logic hi, hi_n, ph_end;
  logic [2:0] cur_channel, prev_channel;
  logic [11:0] shift;
  logic [15:0] din;
  logic cs_nx, sclk_nx, saddr_nx, sample, done;
  assign ph_end = ph == PW'(CLK_DIV - 1);
  assign din = {2'b00, cur_channel, 11'b0};
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state <= IDLE;
      ph <= '0;
      bc <= '0;
      hi <= 1'b0;
    end else begin
      state <= state_n;
      ph <= ph_n;
      bc <= bc_n;
      hi <= hi_n;
    end
  end
  always_comb begin
    state_n = state;
    ph_n = ph_end ? '0 : ph + 1'b1;
    bc_n = bc;
    hi_n = hi;
    case (state)
      IDLE: begin
        ph_n = '0;
        state_n = start ? SETUP : IDLE;
      end
      SETUP: if (ph_end) begin
        state_n = SHIFT;
        hi_n = 1'b0;
        bc_n = '0;
      end
      SHIFT: if (ph_end) begin
        hi_n = !hi;
        // the 16th high phase closes the frame; the bit counter never wraps
        if (hi && bc == 4'd15) state_n = QUIET;
        else if (hi) bc_n = bc + 4'd1;
      end
      QUIET: state_n = ph_end ? IDLE : QUIET;
    endcase
  end
  // outputs are registered copies of what the next state demands
  always_comb begin
    cs_nx = !(state_n == SETUP || state_n == SHIFT);
    sclk_nx = !(state_n == SHIFT && !hi_n);
    saddr_nx = state_n == SHIFT && din[4'd15 - bc_n];
    sample = state == SHIFT && !hi && ph_end;
    done = state == SHIFT && state_n == QUIET;
  end
  always_ff @(posedge clock_50) begin
    if (reset) begin
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b1;
      adc_saddr <= 1'b0;
      busy <= 1'b0;
      valid <= 1'b0;
      data <= '0;
      data_channel <= '0;
      prev_channel <= '0;
      cur_channel <= '0;
      shift <= '0;
    end else begin
      adc_cs_n <= cs_nx;
      adc_sclk <= sclk_nx;
      adc_saddr <= saddr_nx;
      busy <= state_n != IDLE;
      valid <= done;
      if (state == IDLE && start) cur_channel <= channel;
      // 12 bits deep: the four leading zeros fall off the top
      if (sample) shift <= {shift[10:0], adc_sdat};
      if (done) begin
        data <= shift;
        data_channel <= prev_channel;
        prev_channel <= cur_channel;
      end
    end
  end
endmodule
